idex_skid_stage: RTL and testbench

IDEX_SKID_STAGE -- requirements
Module: idex_skid_stage

---
 rtl/idex_skid_stage_pkg.sv | 81 ++++++++
 rtl/pipe_reg_slot.sv | 34 +++
 rtl/idex_skid_stage.sv | 119 +++++++++++
 tb/tb_idex_skid_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/idex_skid_stage_pkg.sv
// Shared ID/EX pipeline definitions: default widths, occupancy encoding
// and the skid-buffer next-state step used by idex_skid_stage.
package idex_skid_stage_pkg;

    localparam int unsigned IDEX_DATA_W = 128;
    localparam int unsigned IDEX_CTRL_W = 16;
    localparam int unsigned IDEX_ADDR_W = 14;
    localparam int unsigned IDEX_CNT_W  = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'd0,
        MAIN_FROM_IN   = 2'd1,
        MAIN_FROM_SKID = 2'd2,
        MAIN_CLEAR     = 2'd3
    } main_sel_t;

    typedef struct packed {
        occ_t      nxt;
        main_sel_t main_sel;
        logic      skid_load;
        logic      skid_clr;
    } skid_ctl_t;

    function automatic skid_ctl_t skid_step(
        input occ_t cur,
        input logic flush,
        input logic accept,
        input logic pop
    );
        skid_ctl_t c;
        c.nxt       = cur;
        c.main_sel  = MAIN_HOLD;
        c.skid_load = 1'b0;
        c.skid_clr  = 1'b0;
        if (flush) begin
            c.nxt      = OCC_EMPTY;
            c.main_sel = MAIN_CLEAR;
            c.skid_clr = 1'b1;
        end else begin
            unique case (cur)
                OCC_EMPTY: begin
                    if (accept) begin
                        c.nxt      = OCC_ONE;
                        c.main_sel = MAIN_FROM_IN;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        c.main_sel = MAIN_FROM_IN;
                    end else if (accept) begin
                        c.nxt       = OCC_TWO;
                        c.skid_load = 1'b1;
                    end else if (pop) begin
                        c.nxt      = OCC_EMPTY;
                        c.main_sel = MAIN_CLEAR;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        c.nxt      = OCC_ONE;
                        c.main_sel = MAIN_FROM_SKID;
                        c.skid_clr = 1'b1;
                    end
                end
                default: begin
                    c.nxt      = OCC_EMPTY;
                    c.main_sel = MAIN_CLEAR;
                    c.skid_clr = 1'b1;
                end
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_reg_slot.sv
// One pipeline-register slot: ctrl/data/addr with load enable.
// Clearing zeroes only ctrl so a dead slot decodes as a NOP.
module pipe_reg_slot #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clr_ctrl,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    input  logic [ADDR_W-1:0] addr_d,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q,
    output logic [ADDR_W-1:0] addr_q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            data_q <= '0;
            addr_q <= '0;
        end else if (load) begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
            addr_q <= addr_d;
        end else if (clr_ctrl) begin
            ctrl_q <= '0;
        end
    end

endmodule

// File: rtl/idex_skid_stage.sv
// ID/EX pipeline register as a 2-entry skid buffer with registered
// in_ready_o, flush, NOP-on-empty ctrl and a saturating bubble counter.
module idex_skid_stage
    import idex_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W = IDEX_DATA_W,
    parameter int unsigned CTRL_W = IDEX_CTRL_W,
    parameter int unsigned ADDR_W = IDEX_ADDR_W,
    parameter int unsigned CNT_W  = IDEX_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    occ_t             occ_q;
    logic             in_ready_q;
    logic [CNT_W-1:0] bubble_q;
    skid_ctl_t        ctl;

    logic accept;
    logic pop;
    logic bubble;

    logic              main_load;
    logic              main_clr;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;
    logic [ADDR_W-1:0] main_addr_d;

    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_addr;

    assign out_valid_o  = (occ_q != OCC_EMPTY);
    assign in_ready_o   = in_ready_q;
    assign bubble_cnt_o = bubble_q;

    assign accept = in_valid_i & in_ready_q;
    assign pop    = out_valid_o & out_ready_i;
    assign bubble = out_ready_i & ~out_valid_o & ~flush_i;
    assign ctl    = skid_step(occ_q, flush_i, accept, pop);

    assign main_load = (ctl.main_sel == MAIN_FROM_IN) ||
                       (ctl.main_sel == MAIN_FROM_SKID);
    assign main_clr  = (ctl.main_sel == MAIN_CLEAR);

    always_comb begin
        main_ctrl_d = in_ctrl_i;
        main_data_d = in_data_i;
        main_addr_d = in_addr_i;
        if (ctl.main_sel == MAIN_FROM_SKID) begin
            main_ctrl_d = skid_ctrl;
            main_data_d = skid_data;
            main_addr_d = skid_addr;
        end
    end

    pipe_reg_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_main (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (main_load),
        .clr_ctrl (main_clr),
        .ctrl_d   (main_ctrl_d),
        .data_d   (main_data_d),
        .addr_d   (main_addr_d),
        .ctrl_q   (out_ctrl_o),
        .data_q   (out_data_o),
        .addr_q   (out_addr_o)
    );

    pipe_reg_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ctl.skid_load),
        .clr_ctrl (ctl.skid_clr),
        .ctrl_d   (in_ctrl_i),
        .data_d   (in_data_i),
        .addr_d   (in_addr_i),
        .ctrl_q   (skid_ctrl),
        .data_q   (skid_data),
        .addr_q   (skid_addr)
    );

    // in_ready is the registered image of the next occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q      <= OCC_EMPTY;
            in_ready_q <= 1'b1;
            bubble_q   <= '0;
        end else begin
            occ_q      <= ctl.nxt;
            in_ready_q <= (ctl.nxt != OCC_TWO);
            if (bubble && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_idex_skid_stage.sv
// Directed table plus hand sequences and a queue-model random run
// for the ID/EX skid stage.
module tb_idex_skid_stage;

    logic         clk;
    logic         rst_n;
    logic         flush_i;
    logic         in_valid_i;
    logic [15:0]  in_ctrl_i;
    logic [127:0] in_data_i;
    logic [13:0]  in_addr_i;
    logic         out_ready_i;

    logic         in_ready_o;
    logic         out_valid_o;
    logic [15:0]  out_ctrl_o;
    logic [127:0] out_data_o;
    logic [13:0]  out_addr_o;
    logic [15:0]  bubble_cnt_o;

    logic         s_in_ready;
    logic         s_out_valid;
    logic [15:0]  s_out_ctrl;
    logic [127:0] s_out_data;
    logic [13:0]  s_out_addr;
    logic [3:0]   s_bubble_cnt;

    int total = 0;
    int bad = 0;

    idex_skid_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_ctrl_i    (in_ctrl_i),
        .in_data_i    (in_data_i),
        .in_addr_i    (in_addr_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_ctrl_o   (out_ctrl_o),
        .out_data_o   (out_data_o),
        .out_addr_o   (out_addr_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    idex_skid_stage #(.CNT_W(4)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (s_in_ready),
        .in_ctrl_i    (in_ctrl_i),
        .in_data_i    (in_data_i),
        .in_addr_i    (in_addr_i),
        .out_valid_o  (s_out_valid),
        .out_ready_i  (out_ready_i),
        .out_ctrl_o   (s_out_ctrl),
        .out_data_o   (s_out_data),
        .out_addr_o   (s_out_addr),
        .bubble_cnt_o (s_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] tag;
        logic        ev;
        logic        erdy;
        logic [31:0] etag;
        int          ebub;
    } vec_t;

    vec_t vt[$];

    function automatic logic [127:0] mkdata(input logic [31:0] t);
        return {t, ~t, t ^ 32'h5a5a_5a5a, t};
    endfunction

    function automatic logic [15:0] mkctrl(input logic [31:0] t);
        return {1'b1, t[14:0]};
    endfunction

    function automatic logic [13:0] mkaddr(input logic [31:0] t);
        return t[13:0] ^ 14'h2a5;
    endfunction

    task automatic add(input logic r, input logic f, input logic v,
                       input logic o, input int t, input logic ev,
                       input logic erdy, input int et, input int eb);
        vec_t x;
        x.rst = r; x.fl = f; x.iv = v; x.ordy = o; x.tag = t;
        x.ev = ev; x.erdy = erdy; x.etag = et; x.ebub = eb;
        vt.push_back(x);
    endtask

    task automatic drive(input logic r, input logic f, input logic v,
                         input logic o, input logic [31:0] t);
        rst_n = r;
        flush_i = f;
        in_valid_i = v;
        out_ready_i = o;
        in_ctrl_i = mkctrl(t);
        in_data_i = mkdata(t);
        in_addr_i = mkaddr(t);
    endtask

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [31:0] q[$];
    logic [31:0] lastd;
    logic [31:0] tagc;
    logic        rv, ro, rf, acc, pp;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        add(0,0,0,0,0,  0,1,0,0);
        add(1,0,1,1,1,  1,1,1,1);
        for (int k = 2; k <= 8; k++) add(1,0,1,1,k, 1,1,k,1);
        add(1,0,0,1,0,  0,1,0,1);
        add(1,0,1,0,10, 1,1,10,1);
        add(1,0,1,0,11, 1,0,10,1);
        add(1,0,1,0,12, 1,0,10,1);
        add(1,0,0,1,0,  1,1,11,1);
        add(1,0,0,1,0,  0,1,0,1);
        add(1,0,0,1,0,  0,1,0,2);
        add(1,0,1,0,16, 1,1,16,2);
        add(1,0,1,0,17, 1,0,16,2);
        add(1,1,1,0,18, 0,1,0,2);
        add(1,1,1,0,19, 0,1,0,2);
        add(1,0,0,1,0,  0,1,0,3);
        add(1,0,1,0,21, 1,1,21,3);
        add(1,0,1,0,22, 1,0,21,3);
        add(0,0,1,1,23, 0,1,0,0);
        add(1,0,1,0,24, 1,1,24,0);
        add(1,0,0,1,0,  0,1,0,0);
        add(1,0,0,1,0,  0,1,0,1);
        add(1,0,1,0,27, 1,1,27,1);
        add(1,0,0,0,0,  1,1,27,1);
        add(1,0,0,1,0,  0,1,0,1);

        lastd = 32'd0;
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].ordy, vt[i].tag);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.valid", i), 128'(out_valid_o), 128'(vt[i].ev));
            chk($sformatf("v%0d.ready", i), 128'(in_ready_o), 128'(vt[i].erdy));
            chk($sformatf("v%0d.ctrl", i), 128'(out_ctrl_o),
                vt[i].ev ? 128'(mkctrl(vt[i].etag)) : 128'd0);
            if (!vt[i].rst) begin
                lastd = 32'd0;
                chk($sformatf("v%0d.data", i), out_data_o, 128'd0);
                chk($sformatf("v%0d.addr", i), 128'(out_addr_o), 128'd0);
            end else begin
                if (vt[i].ev) lastd = vt[i].etag;
                chk($sformatf("v%0d.data", i), out_data_o, mkdata(lastd));
                chk($sformatf("v%0d.addr", i), 128'(out_addr_o),
                    128'(mkaddr(lastd)));
            end
            chk($sformatf("v%0d.bubble", i), 128'(bubble_cnt_o),
                128'(vt[i].ebub));
        end

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        @(posedge clk);
        #1;
        chk("sat.reset", 128'(s_bubble_cnt), 128'd0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("sat.c%0d", k), 128'(s_bubble_cnt),
                128'((k > 15) ? 15 : k));
        end

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        q.delete();
        tagc = 32'd1000;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            rv = ($urandom_range(0, 99) < 60);
            ro = ($urandom_range(0, 99) < 70);
            rf = ($urandom_range(0, 99) < 3);
            drive(1'b1, rf, rv, ro, tagc);
            #1;
            chk($sformatf("r%0d.valid", n), 128'(out_valid_o),
                128'(q.size() != 0));
            chk($sformatf("r%0d.ready", n), 128'(in_ready_o),
                128'(q.size() < 2));
            if (q.size() != 0) begin
                chk($sformatf("r%0d.data", n), out_data_o, mkdata(q[0]));
                chk($sformatf("r%0d.ctrl", n), 128'(out_ctrl_o),
                    128'(mkctrl(q[0])));
            end else begin
                chk($sformatf("r%0d.ctrl0", n), 128'(out_ctrl_o), 128'd0);
            end
            out_ready_i = ~ro;
            #1;
            chk($sformatf("r%0d.rdycomb", n), 128'(in_ready_o),
                128'(q.size() < 2));
            out_ready_i = ro;
            acc = rv && (q.size() < 2);
            pp = ro && (q.size() != 0);
            @(posedge clk);
            if (rf) begin
                q.delete();
            end else begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back(tagc);
            end
            tagc = tagc + 32'd1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
